// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM channel scheduler: state encoding,
// channel/select widths and the one-hot select decode.
package tdm_pkg;

  localparam int NCH   = 4;
  localparam int SEL_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  function automatic logic [NCH-1:0] sel_decode(input logic [SEL_W-1:0] s);
    logic [NCH-1:0] oh;
    oh    = '0;
    oh[s] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/tdm_channel_scheduler_rr_pick.sv
// Round-robin picker: first set request bit scanning ptr, ptr+1, ... mod 4.
module rr_pick
  import tdm_pkg::*;
(
  input  logic [NCH-1:0]   req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] pick,
  output logic             any
);

  logic [SEL_W-1:0] idx;

  // Scan from the farthest candidate back to ptr so the nearest one wins.
  always_comb begin
    pick = ptr;
    any  = |req;
    idx  = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      idx = ptr + SEL_W'(k);
      if (req[idx]) pick = idx;
    end
  end

endmodule

// File: rtl/tdm_channel_scheduler.sv
// TDM scheduler driving a 4-channel mux: round-robin grants of DWELL cycles
// separated by a one-cycle gap. Optional macro EARLY_RELEASE_EN ends a grant
// as soon as the granted channel drops its request.
module tdm_channel_scheduler #(
  parameter int NCH   = 4,
  parameter int DWELL = 4,
  parameter int CNT_W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [NCH-1:0] req,
  output logic [1:0]     sel,
  output logic           en,
  output logic           en_a,
  output logic           en_b,
  output logic           en_c,
  output logic           en_d,
  output logic           slot_done
);
  import tdm_pkg::*;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);

  state_t           state;
  logic [1:0]       ptr;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       pick;
  logic             any;
  logic             last;
  logic             release_grant;

  rr_pick u_rr_pick (
    .req  (req),
    .ptr  (ptr),
    .pick (pick),
    .any  (any)
  );

  assign last = (cnt == LAST_CNT);

`ifdef EARLY_RELEASE_EN
  assign release_grant = last || !req[sel];
`else
  assign release_grant = last;
`endif

  // Derived only from registered state/count (and req when early release is on).
  assign slot_done = (state == GRANT) && release_grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sel   <= '0;
      en    <= 1'b0;
      en_a  <= 1'b0;
      en_b  <= 1'b0;
      en_c  <= 1'b0;
      en_d  <= 1'b0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE, GAP: begin
          if (any) begin
            state                  <= GRANT;
            sel                    <= pick;
            en                     <= 1'b1;
            cnt                    <= '0;
            {en_d, en_c, en_b, en_a} <= sel_decode(pick);
          end else begin
            state <= IDLE;
          end
        end
        GRANT: begin
          if (release_grant) begin
            // Break-before-make: all enables drop for one cycle, sel holds.
            state                  <= GAP;
            en                     <= 1'b0;
            {en_d, en_c, en_b, en_a} <= 4'b0000;
            ptr                    <= sel + 2'd1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state                  <= IDLE;
          en                     <= 1'b0;
          {en_d, en_c, en_b, en_a} <= 4'b0000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tdm_channel_scheduler.sv
// Scoreboard bench for tdm_channel_scheduler: DWELL=4 and DWELL=1 instances
// share req/rst_n and are checked every cycle against a grant-level model.
module tb_tdm_channel_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;

  logic [1:0] sel4, sel1;
  logic       en4, en_a4, en_b4, en_c4, en_d4, sd4;
  logic       en1, en_a1, en_b1, en_c1, en_d1, sd1;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];

  // Model: one entry per instance; m_pos is the 1-based cycle within a grant.
  int         dw[2];
  logic       m_en[2];
  logic [1:0] m_sel[2];
  logic [1:0] m_ptr[2];
  int         m_pos[2];

  always #5 clk = ~clk;

  tdm_channel_scheduler #(.NCH(4), .DWELL(4), .CNT_W(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .req(req), .sel(sel4), .en(en4),
    .en_a(en_a4), .en_b(en_b4), .en_c(en_c4), .en_d(en_d4), .slot_done(sd4)
  );

  tdm_channel_scheduler #(.NCH(4), .DWELL(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req), .sel(sel1), .en(en1),
    .en_a(en_a1), .en_b(en_b1), .en_c(en_c1), .en_d(en_d1), .slot_done(sd1)
  );

  function automatic logic early_drop(int i, logic [3:0] r);
`ifdef EARLY_RELEASE_EN
    return m_en[i] && !r[m_sel[i]];
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [7:0] expect_of(int i, logic [3:0] r);
    logic       sd;
    logic [3:0] oh;
    sd = (m_en[i] && (m_pos[i] == dw[i])) || early_drop(i, r);
    oh = m_en[i] ? (4'b0001 << m_sel[i]) : 4'b0000;
    return {sd, oh, m_en[i], m_sel[i]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_en[i]  = 1'b0;
      m_sel[i] = 2'd0;
      m_ptr[i] = 2'd0;
      m_pos[i] = 0;
    end
  endtask

  task automatic model_edge(int i, logic [3:0] r);
    int c;
    if (m_en[i]) begin
      if (m_pos[i] == dw[i] || early_drop(i, r)) begin
        m_en[i]  = 1'b0;
        m_ptr[i] = m_sel[i] + 2'd1;
      end else begin
        m_pos[i] = m_pos[i] + 1;
      end
    end else if (r != 4'b0000) begin
      c = 0;
      for (int k = 3; k >= 0; k--)
        if (r[(int'(m_ptr[i]) + k) % 4]) c = (int'(m_ptr[i]) + k) % 4;
      m_en[i]  = 1'b1;
      m_sel[i] = 2'(c);
      m_pos[i] = 1;
    end
  endtask

  // One clock: model the edge with the req the DUT sampled, then drive the
  // next cycle's inputs and queue what both instances must show.
  task automatic step(logic [3:0] r, logic rst);
    @(posedge clk);
    if (rst_n)
      for (int i = 0; i < 2; i++) model_edge(i, req);
    #1;
    req = r;
    if (rst) begin
      rst_n = 1'b0;
      model_reset();
    end else begin
      rst_n = 1'b1;
    end
    q0.push_back(expect_of(0, r));
    q1.push_back(expect_of(1, r));
  endtask

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (q0.size() > 0)
      chk($sformatf("dwell4 cyc=%0d {sd,en_dcba,en,sel}", cyc),
          {sd4, en_d4, en_c4, en_b4, en_a4, en4, sel4}, q0.pop_front());
    if (q1.size() > 0)
      chk($sformatf("dwell1 cyc=%0d {sd,en_dcba,en,sel}", cyc),
          {sd1, en_d1, en_c1, en_b1, en_a1, en1, sel1}, q1.pop_front());
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] r;
    int         n;
    dw[0] = 4;
    dw[1] = 1;
    rst_n = 1'b0;
    req   = 4'b0000;
    model_reset();
    repeat (3) step(4'b0000, 1'b1);

    // Single requester: 4-cycle grants, gap, re-grant
    repeat (12) step(4'b0001, 1'b0);
    // All requesting: rotation 0,1,2,3,0
    repeat (30) step(4'b1111, 1'b0);
    // Two requesters alternating
    repeat (16) step(4'b0101, 1'b0);

    // Asynchronous reset at the second cycle of a grant
    repeat (2) step(4'b0000, 1'b0);
    repeat (2) step(4'b0001, 1'b0);
    step(4'b0001, 1'b1);
    #1;
    chk("async reset dwell4 {en_dcba,en,sel}",
        {en_d4, en_c4, en_b4, en_a4, en4, sel4}, 8'h00);
    chk("async reset dwell1 {en_dcba,en,sel}",
        {en_d1, en_c1, en_b1, en_a1, en1, sel1}, 8'h00);
    step(4'b0010, 1'b1);
    repeat (8) step(4'b0010, 1'b0);

    // Granted channel drops its request in grant cycle 2
    repeat (2) step(4'b0000, 1'b0);
    repeat (2) step(4'b0001, 1'b0);
    repeat (8) step(4'b0000, 1'b0);

    // Channels 0 and 3 alternating (single-cycle grants on the DWELL=1 copy)
    repeat (12) step(4'b1001, 1'b0);

    // Randomized traffic with occasional resets and single-bit drops
    repeat (600) begin
      r = 4'($urandom);
      n = $urandom_range(1, 8);
      repeat (n) begin
        if ($urandom_range(0, 3) == 0) r[$urandom_range(0, 3)] = 1'b0;
        step(r, ($urandom_range(0, 99) == 0));
      end
    end

    step(4'b0000, 1'b0);
    @(negedge clk);
    #1;
    chk("scoreboard drained", 8'(q0.size() + q1.size()), 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
